// File: rtl/register_file.sv
// register_file: NREG x XLEN register file with two combinational read ports and one synchronous write port; x0 reads 0.
// Ports: clk; rst (synchronous, active-high, clears all registers);
//   RegWEn/rsW/dataW form the write port; rsR1->dataR1 and rsR2->dataR2 are the read ports.
// Build option: define REGFILE_BYPASS_EN to forward dataW to a read port that addresses the register being written.
module register_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWEn,
  input  logic [4:0]      rsR1,
  input  logic [4:0]      rsR2,
  input  logic [4:0]      rsW,
  input  logic [XLEN-1:0] dataW,
  output logic [XLEN-1:0] dataR1,
  output logic [XLEN-1:0] dataR2
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [XLEN-1:0] rd1, rd2;
  logic            we;
  assign we = RegWEn && rsW != 5'd0;
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[rsW] = dataW;
  end
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end
  assign rd1 = (rsR1 == 5'd0) ? '0 : regs_q[rsR1];
  assign rd2 = (rsR2 == 5'd0) ? '0 : regs_q[rsR2];
`ifdef REGFILE_BYPASS_EN
  // we already excludes rsW==0, so a matching read index is nonzero too
  assign dataR1 = (we && !rst && rsW == rsR1) ? dataW : rd1;
  assign dataR2 = (we && !rst && rsW == rsR2) ? dataW : rd2;
`else
  assign dataR1 = rd1;
  assign dataR2 = rd2;
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized check of register_file against an array model, plus hand-computed scenarios.
module tb_register_file;
  localparam logic [31:0] BA = 32'hBABABABA;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst, RegWEn;
  logic [4:0]  rsR1, rsR2, rsW;
  logic [31:0] dataW, dataR1, dataR2;
  logic [31:0] model [32];
  bit          armed = 1'b0;
  int          checks = 0;
  int          errors = 0;

  register_file dut (
    .clk(clk), .rst(rst), .RegWEn(RegWEn), .rsR1(rsR1), .rsR2(rsR2),
    .rsW(rsW), .dataW(dataW), .dataR1(dataR1), .dataR2(dataR2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (BYP && RegWEn && !rst && rsW == idx) return dataW;
    return model[idx];
  endfunction

  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 32; i++) model[i] = 32'h0;
    else if (RegWEn && rsW != 0) model[rsW] = dataW;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_r1", dataR1, expect_rd(rsR1));
      chk("model_r2", dataR2, expect_rd(rsR2));
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; RegWEn = 1'b0; rsR1 = 0; rsR2 = 0; rsW = 0; dataW = 0;
    #2 chk("x0_before_reset", dataR1, 32'h0);
    edge1(); edge1();
    rst = 1'b0; rsR1 = 3; rsR2 = 3;
    armed = 1'b1;
    #1 chk("reset_r1", dataR1, 32'h0);
    chk("reset_r2", dataR2, 32'h0);
    rsW = 3; dataW = BA;
    edge1(); edge1();
    chk("wen0_x3", dataR1, 32'h0);
    RegWEn = 1'b1;
    #1 chk("x3_pre_edge", dataR1, BYP ? BA : 32'h0);
    edge1();
    RegWEn = 1'b0;
    #1 chk("x3_r1", dataR1, BA);
    chk("x3_r2", dataR2, BA);
    rsR1 = 4; rsR2 = 5; RegWEn = 1'b1; rsW = 4;
    #1 chk("x4_pre_edge", dataR1, BYP ? BA : 32'h0);
    edge1();
    rsW = 5;
    #1 chk("x4_post_edge", dataR1, BA);
    chk("x5_pre_edge", dataR2, BYP ? BA : 32'h0);
    edge1();
    RegWEn = 1'b0;
    #1 chk("x5_post_edge", dataR2, BA);
    RegWEn = 1'b1; rsW = 0; rsR1 = 0;
    #1 chk("x0_pre_edge", dataR1, 32'h0);
    edge1();
    chk("x0_post_edge", dataR1, 32'h0);
    rst = 1'b1; RegWEn = 1'b1; rsW = 3; dataW = 32'h12345678; rsR1 = 3; rsR2 = 4;
    #1 chk("rst_pre_edge", dataR1, BA);
    edge1();
    rst = 1'b0; RegWEn = 1'b0;
    #1 chk("rst_x3", dataR1, 32'h0);
    chk("rst_x4", dataR2, 32'h0);
    rsR1 = 5;
    #1 chk("rst_x5", dataR1, 32'h0);
    for (int n = 0; n < 1500; n++) begin
      edge1();
      rst    = ($urandom_range(0, 59) == 0);
      RegWEn = ($urandom_range(0, 2) != 0);
      rsW    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      rsR1   = ($urandom_range(0, 3) == 0) ? rsW : 5'($urandom_range(0, 6));
      rsR2   = ($urandom_range(0, 3) == 0) ? rsR1 : 5'($urandom_range(0, 31));
      dataW  = $urandom;
    end
    edge1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
